// File: rtl/alu_pkg.sv
// Shared constants for the sequential Hack ALU:
// ctrl bit positions, Hack opcodes, FSM encoding.
package alu_pkg;

  localparam int ZX = 5;
  localparam int NX = 4;
  localparam int ZY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;

  localparam logic [5:0] OP_ZERO = 6'b101010;
  localparam logic [5:0] OP_ONE  = 6'b111111;
  localparam logic [5:0] OP_NEG1 = 6'b111010;
  localparam logic [5:0] OP_X    = 6'b001100;
  localparam logic [5:0] OP_Y    = 6'b110000;
  localparam logic [5:0] OP_NOTX = 6'b001101;
  localparam logic [5:0] OP_NOTY = 6'b110001;
  localparam logic [5:0] OP_NEGX = 6'b001111;
  localparam logic [5:0] OP_NEGY = 6'b110011;
  localparam logic [5:0] OP_XP1  = 6'b011111;
  localparam logic [5:0] OP_YP1  = 6'b110111;
  localparam logic [5:0] OP_XM1  = 6'b001110;
  localparam logic [5:0] OP_YM1  = 6'b110010;
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_XMY  = 6'b010011;
  localparam logic [5:0] OP_YMX  = 6'b000111;
  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b010101;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Combinational Hack ALU datapath, WIDTH bits wide.
// Produces only the result word; flags live in the registered wrapper.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] xa, xb, ya, yb, r;

  always_comb begin
    xa  = ctrl[ZX] ? '0 : x;
    xb  = ctrl[NX] ? ~xa : xa;
    ya  = ctrl[ZY] ? '0 : y;
    yb  = ctrl[NY] ? ~ya : ya;
    r   = ctrl[F] ? (xb + yb) : (xb & yb);
    out = ctrl[NO] ? ~r : r;
  end

endmodule

// File: rtl/hack_alu_seq.sv
// Registered Hack ALU with valid/ready handshakes and an
// iterative shift-add multiply that takes WIDTH cycles.
module hack_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] core_out;
  logic             accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x    (x),
    .y    (y),
    .ctrl (ctrl),
    .out  (core_out)
  );

  assign in_ready = (state == ST_IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (state == ST_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        out       <= acc_next;
        zr        <= (acc_next == '0);
        ng        <= acc_next[WIDTH-1];
        out_valid <= 1'b1;
        busy      <= 1'b0;
        state     <= ST_IDLE;
      end
    end else if (accept && mul) begin
      // accept implies any pending result is consumed this edge
      mcand     <= x;
      mplier    <= y;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      state     <= ST_MUL;
    end else if (accept) begin
      out       <= core_out;
      zr        <= (core_out == '0);
      ng        <= core_out[WIDTH-1];
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hack_alu_seq.sv
// Directed bench for hack_alu_seq: opcode-level reference model
// compared every cycle, plus literal expectations from the test plan.
module tb_hack_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [5:0]   ctrl = '0;
  logic         mul = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         zr;
  logic         ng;
  logic         busy;

  int errors = 0;
  int checks = 0;

  hack_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .mul       (mul),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] hack_ref(input logic [5:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (op)
      OP_ZERO: return '0;
      OP_ONE:  return W'(1);
      OP_NEG1: return '1;
      OP_X:    return a;
      OP_Y:    return b;
      OP_NOTX: return ~a;
      OP_NOTY: return ~b;
      OP_NEGX: return W'(0) - a;
      OP_NEGY: return W'(0) - b;
      OP_XP1:  return a + W'(1);
      OP_YP1:  return b + W'(1);
      OP_XM1:  return a - W'(1);
      OP_YM1:  return b - W'(1);
      OP_ADD:  return a + b;
      OP_XMY:  return a - b;
      OP_YMX:  return b - a;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return 'x;
    endcase
  endfunction

  // reference model: result word, valid flag, multiply countdown
  logic         m_ov;
  logic [W-1:0] m_out;
  logic [W-1:0] m_prod;
  int           m_left;
  logic         m_ready;

  assign m_ready = (m_left == 0) && (!m_ov || out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov   <= 1'b0;
      m_out  <= '0;
      m_prod <= '0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_ov  <= 1'b1;
        m_out <= m_prod;
      end
    end else if (in_valid && m_ready) begin
      if (mul) begin
        m_prod <= W'(32'(x) * 32'(y));
        m_left <= W;
        m_ov   <= 1'b0;
      end else begin
        m_out <= hack_ref(ctrl, x, y);
        m_ov  <= 1'b1;
      end
    end else if (m_ov && out_ready) begin
      m_ov <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("m_out_valid", 32'(out_valid), 32'(m_ov));
    chk("m_in_ready", 32'(in_ready), 32'(m_ready));
    chk("m_busy", 32'(busy), 32'(m_left > 0));
    if (m_ov) begin
      chk("m_out", 32'(out), 32'(m_out));
      chk("m_zr", 32'(zr), 32'(m_out == '0));
      chk("m_ng", 32'(ng), 32'(m_out[W-1]));
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [5:0] c, input logic m);
    bit got = 0;
    x = a; y = b; ctrl = c; mul = m;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] e,
                             input logic ezr, input logic eng);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_out"}, 32'(out), 32'(e));
    chk({name, "_zr"}, 32'(zr), 32'(ezr));
    chk({name, "_ng"}, 32'(ng), 32'(eng));
  endtask

  logic [5:0] ops [18] = '{OP_ZERO, OP_ONE, OP_NEG1, OP_X, OP_Y,
                           OP_NOTX, OP_NOTY, OP_NEGX, OP_NEGY, OP_XP1,
                           OP_YP1, OP_XM1, OP_YM1, OP_ADD, OP_XMY,
                           OP_YMX, OP_AND, OP_OR};

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_zr", 32'(zr), 32'd0);
    chk("rst_ng", 32'(ng), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: add, single-cycle valid pulse
    send(16'h000F, 16'h0003, OP_ADD, 1'b0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_out", 32'(out), 32'h0012);
    chk("add_zr", 32'(zr), 32'd0);
    chk("add_ng", 32'(ng), 32'd0);
    @(posedge clk);
    #1;
    chk("add_pulse_end", 32'(out_valid), 32'd0);

    // 2: y-x, then all 18 opcodes back to back
    send(16'h000F, 16'h0003, OP_YMX, 1'b0);
    chk("ymx_out", 32'(out), 32'hFFF4);
    chk("ymx_ng", 32'(ng), 32'd1);
    foreach (ops[i]) begin
      send(16'h000F, 16'h0003, ops[i], 1'b0);
      chk("sweep_valid", 32'(out_valid), 32'd1);
      if (i == 0) begin
        chk("zero_out", 32'(out), 32'h0000);
        chk("zero_zr", 32'(zr), 32'd1);
      end
    end
    @(posedge clk);
    #1;

    // 3: backpressure holds result and blocks input
    send(16'h000F, 16'h0003, OP_XP1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out", 32'(out), 32'h0010);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    send(16'h0005, 16'h0002, OP_XMY, 1'b0);
    chk("bp_next_out", 32'(out), 32'h0003);

    // 4: multiply latency and result
    send(16'd15, 16'd3, 6'b000000, 1'b1);
    chk("mul_busy0", 32'(busy), 32'd1);
    chk("mul_ready0", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      chk("mul_valid_edge", 32'(out_valid), 32'(i == 16));
      chk("mul_busy_edge", 32'(busy), 32'(i < 16));
      if (i == 16) chk("mul_out", 32'(out), 32'h002D);
    end

    // 5: multiply wrap and sign
    send(16'h0100, 16'h0100, 6'b111111, 1'b1);
    wait_result("mul_wrap", 16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0002, 6'b000000, 1'b1);
    wait_result("mul_neg", 16'hFFFE, 1'b0, 1'b1);

    // 6: reset mid-multiply discards the partial product
    send(16'h1234, 16'h0077, 6'b000000, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("rstmid_no_stale", 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hack_alu_seq.md
Name: hack_alu_seq

Overview:
Registered, parametrised successor to the combinational Hack ALU. It accepts one operation per valid/ready handshake and returns the result with a valid/ready handshake. It executes all 18 Hack control encodings in one cycle. It adds an iterative shift-add multiply mode that takes WIDTH cycles. It sits between the CPU decode stage and the D/A/M writeback path.

Parameters:
WIDTH, 16, data width of x, y and out (minimum 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request present
in_ready  out  1  block can accept a request this cycle
x  in  WIDTH  operand x
y  in  WIDTH  operand y
ctrl  in  6  {zx,nx,zy,ny,f,no}, standard Hack semantics
mul  in  1  1 = multiply x*y; ctrl is ignored
out_valid  out  1  result registers hold a valid result
out_ready  in  1  consumer takes the result this cycle
out  out  WIDTH  result
zr  out  1  out == 0
ng  out  1  out[WIDTH-1]
busy  out  1  multiply in progress

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out=0, zr=0, ng=0, busy=0, state=IDLE, multiply counter=0, accumulator=0.
- Accept condition: accept = in_valid & in_ready.
- in_ready (combinational) = (state==IDLE) & (!out_valid | out_ready). It is 1 after reset.
- Hack op (mul=0):
  - On the accept edge: out <= core(x,y,ctrl); zr and ng are computed from the new out; out_valid <= 1.
  - Latency is 1 cycle.
  - Back-to-back throughput is 1/cycle while out_ready=1.
- Multiply (mul=1):
  - On the accept edge, latch x into the multiplicand register and y into the multiplier register. Clear the accumulator. Counter <= 0. State -> MUL. busy=1.
  - Each MUL cycle: if the multiplier LSB is 1, acc += mcand. Then mcand <<= 1, mplier >>= 1, counter++. All arithmetic is modulo 2^WIDTH.
  - On the cycle where counter==WIDTH-1: out <= final acc, flags updated, out_valid <= 1, state -> IDLE, busy <= 0.
  - out_valid rises WIDTH edges after the accept edge. Result is the low WIDTH bits of the unsigned product. This equals the two's-complement low word for signed operands.
- Pending output during multiply: on a multiply accept, out_valid is cleared when out_ready=1 (the prior result is consumed). Otherwise the accept cannot occur, because in_ready requires it.
- Output handshake:
  - A result leaves when out_valid & out_ready.
  - If no new result is written that edge, out_valid <= 0.
  - If a new Hack op is accepted on the same edge, out_valid stays 1 with the new data.
  - While out_valid & !out_ready, out, zr and ng are held stable.
- State machine: IDLE, MUL. There is no separate hold state; backpressure is handled by in_ready gating.
- Input rules:
  - in_valid with in_ready=0 is ignored, with no side effects.
  - x, y, ctrl and mul are sampled only on the accept edge.
  - Input changes during MUL have no effect.
- Reset mid-operation: asynchronous return to the reset values. The partial product is discarded and no out_valid pulse occurs.
- zr/ng: computed from the registered out. They are valid only while out_valid=1.

Decomposition:
- Package alu_pkg:
  - ctrl bit-index constants ZX..NO.
  - Named 6-bit localparams for the 18 Hack functions: OP_ZERO=101010, OP_ONE=111111, OP_NEG1=111010, OP_X=001100, OP_Y=110000, OP_NOTX=001101, OP_NOTY=110001, OP_NEGX=001111, OP_NEGY=110011, OP_XP1=011111, OP_YP1=110111, OP_XM1=001110, OP_YM1=110010, OP_ADD=000010, OP_XMY=010011, OP_YMX=000111, OP_AND=000000, OP_OR=010101.
  - State encoding IDLE/MUL.
- Sub-module alu_core: combinational Hack ALU, WIDTH-parametrised, producing out only.

Test Plan:
1. WIDTH=16, x=0x000F, y=0x0003, ctrl=OP_ADD, out_ready=1 -> one edge after accept: out=0x0012, zr=0, ng=0, out_valid=1 for exactly 1 cycle.
2. Same operands, ctrl=OP_YMX -> out=0xFFF4, ng=1. Then sweep all 18 OP_* codes back-to-back with in_valid held high -> 18 consecutive out_valid cycles matching Hack expected values (OP_ZERO gives 0x0000, zr=1).
3. Backpressure: OP_XP1 result 0x0010 with out_ready=0 for 5 cycles -> out held at 0x0010, in_ready=0. Raise out_ready -> in_ready=1 the same cycle and a new op is accepted.
4. mul=1, x=15, y=3 -> busy=1 and in_ready=0 for 16 cycles; out=0x002D, out_valid exactly 16 edges after accept.
5. mul=1, x=0x0100, y=0x0100 -> out=0x0000, zr=1. Then x=0xFFFF, y=0x0002 -> out=0xFFFE, ng=1.
6. Assert rst_n=0 mid-multiply (8 cycles in) -> immediately out_valid=0, busy=0, in_ready=1 after release. No stale result appears.
